// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus arbiters.
// Imported by the picker and by every arbiter built on it.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } arb_state_e;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LSU   = 1'b1;

   // Width of the bus timeout counter; TIMEOUT must fit in 1..2**TIMEOUT_W-1.
   localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker: a lone requester wins outright; ties go to port 0 under fixed
// priority, otherwise to the port opposite the previous grant.
module rr_pick2
   import cpu_bus_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_fixed_prio,
   output logic       o_grant,
   output logic       o_any
);

   always_comb begin
      o_any = |i_req;
      if (i_req == 2'b11) begin
         o_grant = i_fixed_prio ? PORT_FETCH : ~i_last_grant;
      end else begin
         o_grant = i_req[1];
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single W_ memory bus between FETCH (port 0) and the LSU (port 1), one
// transaction at a time, with a registered ack/err pulse and a bus timeout abort.
module mem_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_enable,
   input  logic          m0_write_mode,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_data_i,
   output logic [DW-1:0] m0_data_o,
   output logic          m0_ack,
   output logic          m0_err,
   input  logic          m1_enable,
   input  logic          m1_write_mode,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_data_i,
   output logic [DW-1:0] m1_data_o,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [AW-1:0] W_ADDR,
   output logic [DW-1:0] W_DATA_O,
   output logic          W_WRITE,
   output logic          W_STB,
   input  logic          W_ACK,
   input  logic [DW-1:0] W_DATA_I
);

   localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT - 1);

   arb_state_e           r_state;
   logic                 r_winner;
   logic                 r_last_grant;
   logic [TIMEOUT_W-1:0] r_cnt;
   logic [AW-1:0]        r_addr;
   logic [DW-1:0]        r_wdata;
   logic                 r_write;
   logic                 r_stb;
   logic [1:0]           r_ack;
   logic [1:0]           r_err;
   logic [DW-1:0]        r_m0_rdata;
   logic [DW-1:0]        r_m1_rdata;

   logic w_grant;
   logic w_any;

   rr_pick2 u_pick (
      .i_req        ({m1_enable, m0_enable}),
      .i_last_grant (r_last_grant),
      .i_fixed_prio (FIXED_PRIO),
      .o_grant      (w_grant),
      .o_any        (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_winner     <= PORT_FETCH;
         r_last_grant <= PORT_LSU;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_write      <= 1'b0;
         r_stb        <= 1'b0;
         r_ack        <= 2'b00;
         r_err        <= 2'b00;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         r_ack <= 2'b00;
         r_err <= 2'b00;
         case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_winner     <= w_grant;
                  r_last_grant <= w_grant;
                  r_addr       <= w_grant ? m1_addr : m0_addr;
                  r_wdata      <= w_grant ? m1_data_i : m0_data_i;
                  r_write      <= w_grant ? m1_write_mode : m0_write_mode;
                  r_stb        <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= StBusy;
               end
            end
            StBusy: begin
               // A bus ack in the last allowed cycle still counts as success.
               if (W_ACK) begin
                  r_stb           <= 1'b0;
                  r_ack[r_winner] <= 1'b1;
                  if (!r_write) begin
                     if (r_winner) r_m1_rdata <= W_DATA_I;
                     else          r_m0_rdata <= W_DATA_I;
                  end
                  r_state <= StDone;
               end else if (r_cnt == LAST_CNT) begin
                  r_stb           <= 1'b0;
                  r_ack[r_winner] <= 1'b1;
                  r_err[r_winner] <= 1'b1;
                  r_state         <= StDone;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign W_ADDR    = r_addr;
   assign W_DATA_O  = r_wdata;
   assign W_WRITE   = r_write;
   assign W_STB     = r_stb;
   assign m0_ack    = r_ack[0];
   assign m1_ack    = r_ack[1];
   assign m0_err    = r_err[0];
   assign m1_err    = r_err[1];
   assign m0_data_o = r_m0_rdata;
   assign m1_data_o = r_m1_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share
// all inputs; expected ack results are queued at stimulus time and popped on each ack.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_enable, m1_enable, m0_write_mode, m1_write_mode;
   logic [31:0] m0_addr, m1_addr, m0_data_i, m1_data_i;
   logic        W_ACK;
   logic [31:0] W_DATA_I;

   logic [31:0] m0_data_o, m1_data_o, W_ADDR, W_DATA_O;
   logic        m0_ack, m1_ack, m0_err, m1_err, W_WRITE, W_STB;
   logic [31:0] f_m0_data_o, f_m1_data_o, f_W_ADDR, f_W_DATA_O;
   logic        f_m0_ack, f_m1_ack, f_m0_err, f_m1_err, f_W_WRITE, f_W_STB;

   typedef struct packed {
      logic        port;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        q0[$];
   exp_t        qf[$];
   exp_t        e0, ef;
   logic [31:0] sh0[2];
   logic [31:0] shf[2];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_enable(m0_enable), .m0_write_mode(m0_write_mode), .m0_addr(m0_addr),
      .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_enable(m1_enable), .m1_write_mode(m1_write_mode), .m1_addr(m1_addr),
      .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack(m1_ack), .m1_err(m1_err),
      .W_ADDR(W_ADDR), .W_DATA_O(W_DATA_O), .W_WRITE(W_WRITE), .W_STB(W_STB),
      .W_ACK(W_ACK), .W_DATA_I(W_DATA_I)
   );

   mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(1'b1)) dut_f (
      .clk(clk), .rst_n(rst_n),
      .m0_enable(m0_enable), .m0_write_mode(m0_write_mode), .m0_addr(m0_addr),
      .m0_data_i(m0_data_i), .m0_data_o(f_m0_data_o), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
      .m1_enable(m1_enable), .m1_write_mode(m1_write_mode), .m1_addr(m1_addr),
      .m1_data_i(m1_data_i), .m1_data_o(f_m1_data_o), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
      .W_ADDR(f_W_ADDR), .W_DATA_O(f_W_DATA_O), .W_WRITE(f_W_WRITE), .W_STB(f_W_STB),
      .W_ACK(W_ACK), .W_DATA_I(W_DATA_I)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (p) begin
         m1_enable = en; m1_write_mode = wr; m1_addr = a; m1_data_i = d;
      end else begin
         m0_enable = en; m0_write_mode = wr; m0_addr = a; m0_data_i = d;
      end
   endtask

   // Queue the expected ack for each instance; reads without error refresh data_o.
   task automatic push(input logic p0, input logic pf, input logic err,
                       input logic rd, input logic [31:0] rdata);
      exp_t e;
      if (rd && !err) sh0[p0] = rdata;
      e.port = p0; e.err = err; e.data = sh0[p0];
      q0.push_back(e);
      if (rd && !err) shf[pf] = rdata;
      e.port = pf; e.err = err; e.data = shf[pf];
      qf.push_back(e);
   endtask

   task automatic check_bus(input logic [31:0] a, input logic wr, input logic [31:0] d);
      check("bus_stb", 32'(W_STB), 32'h1);
      check("bus_addr", W_ADDR, a);
      check("bus_write", 32'(W_WRITE), 32'(wr));
      check("bus_wdata", W_DATA_O, d);
   endtask

   // Single-master transaction with `waits` bus wait cycles before W_ACK.
   task automatic txn(input logic p, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int waits, input logic [31:0] rdata);
      drive(p, 1'b1, wr, a, d);
      push(p, p, 1'b0, ~wr, rdata);
      step();
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         check_bus(a, wr, d);
         step();
      end
      W_ACK = 1'b1;
      W_DATA_I = rdata;
      @(negedge clk);
      check_bus(a, wr, d);
      step();
      W_ACK = 1'b0;
      drive(p, 1'b0, wr, a, d);
      @(negedge clk);
      check("txn_ack", 32'(p ? m1_ack : m0_ack), 32'h1);
      check("txn_other_ack", 32'(p ? m0_ack : m1_ack), 32'h0);
      check("txn_stb_done", 32'(W_STB), 32'h0);
      step();
   endtask

   always @(negedge clk) begin
      check("err_wo_ack", 32'((m0_err & ~m0_ack) | (m1_err & ~m1_ack)), 32'h0);
      check("f_err_wo_ack", 32'((f_m0_err & ~f_m0_ack) | (f_m1_err & ~f_m1_ack)), 32'h0);
      if (m0_ack || m1_ack) begin
         if (q0.size() == 0) begin
            check("unexp_ack", 32'(m0_ack | m1_ack), 32'h0);
         end else begin
            e0 = q0.pop_front();
            check("ack_both", 32'(m0_ack & m1_ack), 32'h0);
            check("ack_port", 32'(m1_ack), 32'(e0.port));
            check("ack_err", 32'(e0.port ? m1_err : m0_err), 32'(e0.err));
            check("ack_data", e0.port ? m1_data_o : m0_data_o, e0.data);
         end
      end
      if (f_m0_ack || f_m1_ack) begin
         if (qf.size() == 0) begin
            check("f_unexp_ack", 32'(f_m0_ack | f_m1_ack), 32'h0);
         end else begin
            ef = qf.pop_front();
            check("f_ack_both", 32'(f_m0_ack & f_m1_ack), 32'h0);
            check("f_ack_port", 32'(f_m1_ack), 32'(ef.port));
            check("f_ack_err", 32'(ef.port ? f_m1_err : f_m0_err), 32'(ef.err));
            check("f_ack_data", ef.port ? f_m1_data_o : f_m0_data_o, ef.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m0_enable = 0; m1_enable = 0; m0_write_mode = 0; m1_write_mode = 0;
      m0_addr = 0; m1_addr = 0; m0_data_i = 0; m1_data_i = 0;
      W_ACK = 0; W_DATA_I = 0;
      sh0[0] = 0; sh0[1] = 0; shf[0] = 0; shf[1] = 0;

      #3;
      check("rst_stb", 32'(W_STB), 32'h0);
      check("rst_write", 32'(W_WRITE), 32'h0);
      check("rst_addr", W_ADDR, 32'h0);
      check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Port 0 zero-wait read, then port 1 write with three wait cycles.
      txn(1'b0, 1'b0, 32'h100, 32'h0, 0, 32'd24);
      txn(1'b1, 1'b1, 32'h200, 32'hCAFE, 3, 32'hDEAD);

      // Both masters request continuously.
      drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0);
      for (int i = 0; i < 4; i++) begin
         push(1'(i % 2), 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i));
         step();
         W_ACK = 1'b1;
         W_DATA_I = 32'h100 + 32'(i);
         @(negedge clk);
         check("rr_addr", W_ADDR, (i % 2 == 1) ? 32'h2000 : 32'h1000);
         check("fixed_addr", f_W_ADDR, 32'h1000);
         step();
         W_ACK = 1'b0;
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Bus never acks: abort after exactly four strobe cycles.
      drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
      push(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("to_stb", 32'(W_STB), 32'h1);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
      @(negedge clk);
      check("to_stb_low", 32'(W_STB), 32'h0);
      check("to_ack", 32'(m0_ack), 32'h1);
      check("to_err", 32'(m0_err), 32'h1);
      step();

      // Reset in the middle of a port 1 write.
      drive(1'b1, 1'b1, 1'b1, 32'h400, 32'h55);
      step();
      @(negedge clk);
      check("pre_rst_stb", 32'(W_STB), 32'h1);
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_stb", 32'({W_STB, W_WRITE, f_W_STB, f_W_WRITE}), 32'h0);
      check("mid_rst_addr", W_ADDR | f_W_ADDR, 32'h0);
      check("mid_rst_wdata", W_DATA_O | f_W_DATA_O, 32'h0);
      check("mid_rst_data_o", m0_data_o | m1_data_o | f_m0_data_o | f_m1_data_o, 32'h0);
      sh0[0] = 0; sh0[1] = 0; shf[0] = 0; shf[1] = 0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // First tie after reset goes to port 0 in both modes.
      drive(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
      push(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
      step();
      W_ACK = 1'b1;
      W_DATA_I = 32'h99;
      @(negedge clk);
      check("tie_addr", W_ADDR, 32'h500);
      check("f_tie_addr", f_W_ADDR, 32'h500);
      step();
      W_ACK = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("tie_ack0", 32'(m0_ack), 32'h1);
      check("tie_ack1", 32'(m1_ack), 32'h0);
      step();

      // Spurious bus ack while idle.
      W_ACK = 1'b1;
      W_DATA_I = 32'hBAD;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         check("spur_stb", 32'(W_STB), 32'h0);
         check("spur_ack", 32'({m0_ack, m1_ack}), 32'h0);
      end
      W_ACK = 1'b0;
      step();

      // Enable dropped while busy: transfer still completes and acks.
      drive(1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
      push(1'b1, 1'b1, 1'b0, 1'b1, 32'h77);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'h700, 32'h0);
      @(negedge clk);
      check("drop_stb", 32'(W_STB), 32'h1);
      check("drop_addr", W_ADDR, 32'h700);
      step();
      W_ACK = 1'b1;
      W_DATA_I = 32'h77;
      step();
      W_ACK = 1'b0;
      @(negedge clk);
      check("drop_ack", 32'(m1_ack), 32'h1);
      step();
      step();
      step();

      @(negedge clk);
      check("q_pending", 32'(q0.size()), 32'h0);
      check("f_q_pending", 32'(qf.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
